// File: rtl/main_control_fsm_if.sv
// Control/handshake bundle between the LEGv8 main control sequencer and its datapath.
// master = sequencer side, slave = datapath/memory side.
interface main_control_fsm_if;
    logic [10:0] opcode;
    logic        mem_ready;
    logic        zero;
    logic [1:0]  alu_op;
    logic        reg2loc;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        uncond_branch;
    logic        instr_done;
    logic        bus_error;
    logic        illegal_op;

    modport master (
        input  opcode, mem_ready, zero,
        output alu_op, reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               ir_write, pc_write, uncond_branch, instr_done, bus_error, illegal_op
    );

    modport slave (
        output opcode, mem_ready, zero,
        input  alu_op, reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               ir_write, pc_write, uncond_branch, instr_done, bus_error, illegal_op
    );
endinterface

// File: rtl/main_control_fsm.sv
// Multi-cycle LEGv8 main control sequencer: fetch/decode/execute/memory/writeback with
// a memory-ready handshake and per-access timeout.
module main_control_fsm #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    main_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StMemAddr,
        StMemRd,
        StMemWr,
        StWbAlu,
        StWbMem,
        StBranch
    } state_e;

    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [10:0] op_q;

    logic dec_r, dec_addi, dec_mem, dec_branch, dec_legal;
    logic op_is_ldur, op_is_addi, op_is_cbz;
    logic wait_state, timeout;

    logic [1:0] alu_op;
    logic reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic ir_write, pc_write, uncond_branch, instr_done, bus_error, illegal_op;

    always_comb begin
        dec_r      = (bus.opcode == OpAdd) || (bus.opcode == OpSub) ||
                     (bus.opcode == OpAnd) || (bus.opcode == OpOrr);
        dec_addi   = (bus.opcode[10:1] == 10'b1001000100);
        dec_mem    = (bus.opcode == OpLdur) || (bus.opcode == OpStur);
        dec_branch = (bus.opcode[10:3] == 8'b10110100) || (bus.opcode[10:5] == 6'b000101);
        dec_legal  = dec_r || dec_addi || dec_mem || dec_branch;

        op_is_ldur = (op_q == OpLdur);
        op_is_addi = (op_q[10:1] == 10'b1001000100);
        op_is_cbz  = (op_q[10:3] == 8'b10110100);
    end

    // wait_q counts cycles already spent without mem_ready; abort once TIMEOUT have elapsed.
    assign wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout    = wait_state && !bus.mem_ready && (wait_q == TimeoutCnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            wait_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == StDecode) begin
                op_q <= bus.opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (bus.mem_ready) state_d = StDecode;
                else if (timeout)  state_d = StFetch;
            end
            StDecode: begin
                if (dec_r)           state_d = StExecR;
                else if (dec_addi)   state_d = StExecI;
                else if (dec_mem)    state_d = StMemAddr;
                else if (dec_branch) state_d = StBranch;
                else                 state_d = StFetch;
            end
            StExecR, StExecI: state_d = StWbAlu;
            StMemAddr:        state_d = op_is_ldur ? StMemRd : StMemWr;
            StMemRd: begin
                if (bus.mem_ready) state_d = StWbMem;
                else if (timeout)  state_d = StFetch;
            end
            StMemWr: begin
                if (bus.mem_ready || timeout) state_d = StFetch;
            end
            StWbAlu, StWbMem, StBranch: state_d = StFetch;
            default: state_d = StFetch;
        endcase

        // Any transition (including FETCH re-entry after timeout) restarts the count.
        if (wait_state && !bus.mem_ready && !timeout) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = '0;
        end
    end

    always_comb begin
        alu_op        = 2'b00;
        reg2loc       = 1'b0;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        uncond_branch = 1'b0;
        instr_done    = 1'b0;
        bus_error     = 1'b0;
        illegal_op    = 1'b0;
        if (reset_n) begin
            case (state_q)
                StFetch: begin
                    bus_error = timeout;
                    mem_read  = !timeout;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                end
                StDecode: illegal_op = !dec_legal;
                StExecR:  alu_op = 2'b10;
                StExecI: begin
                    alu_op  = 2'b10;
                    alu_src = 1'b1;
                end
                StWbAlu: begin
                    alu_op     = 2'b10;
                    alu_src    = op_is_addi;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                StMemAddr: begin
                    alu_src = 1'b1;
                    reg2loc = 1'b1;
                end
                StMemRd: begin
                    bus_error = timeout;
                    alu_src   = !timeout;
                    mem_read  = !timeout;
                end
                StMemWr: begin
                    bus_error  = timeout;
                    alu_src    = !timeout;
                    reg2loc    = !timeout;
                    mem_write  = !timeout;
                    instr_done = bus.mem_ready;
                end
                StWbMem: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                StBranch: begin
                    instr_done = 1'b1;
                    if (op_is_cbz) begin
                        alu_op   = 2'b01;
                        reg2loc  = 1'b1;
                        pc_write = bus.zero;
                    end else begin
                        uncond_branch = 1'b1;
                        pc_write      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_op        = alu_op;
    assign bus.reg2loc       = reg2loc;
    assign bus.alu_src       = alu_src;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_write     = reg_write;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.uncond_branch = uncond_branch;
    assign bus.instr_done    = instr_done;
    assign bus.bus_error     = bus_error;
    assign bus.illegal_op    = illegal_op;

endmodule

// File: tb/tb_main_control_fsm.sv
// Instruction-level bench: each instruction expands into its expected per-cycle strobe trace,
// driven with random memory latencies, flags and IR noise.
module tb_main_control_fsm;

    localparam int TIMEOUT = 16;

    localparam logic [13:0] A10  = 14'h2000;
    localparam logic [13:0] A01  = 14'h1000;
    localparam logic [13:0] R2L  = 14'h0800;
    localparam logic [13:0] SRC  = 14'h0400;
    localparam logic [13:0] M2R  = 14'h0200;
    localparam logic [13:0] RW   = 14'h0100;
    localparam logic [13:0] MRD  = 14'h0080;
    localparam logic [13:0] MWR  = 14'h0040;
    localparam logic [13:0] IRW  = 14'h0020;
    localparam logic [13:0] PCW  = 14'h0010;
    localparam logic [13:0] UNC  = 14'h0008;
    localparam logic [13:0] DONE = 14'h0004;
    localparam logic [13:0] BERR = 14'h0002;
    localparam logic [13:0] ILL  = 14'h0001;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_CBZ = 4, C_B = 5, C_ILL = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_retire = 0;
    int   seen_retire = 0;

    main_control_fsm_if bus ();

    main_control_fsm #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.instr_done) seen_retire++;
    end

    function automatic logic [13:0] obs();
        return {bus.alu_op, bus.reg2loc, bus.alu_src, bus.mem_to_reg, bus.reg_write,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.uncond_branch,
                bus.instr_done, bus.bus_error, bus.illegal_op};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic int classify(input logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return C_R;
        if (op[10:1] == 10'b1001000100) return C_I;
        if (op == 11'b11111000010) return C_LD;
        if (op == 11'b11111000000) return C_ST;
        if (op[10:3] == 8'b10110100) return C_CBZ;
        if (op[10:5] == 6'b000101) return C_B;
        return C_ILL;
    endfunction

    function automatic logic [10:0] rop();
        return 11'($urandom);
    endfunction

    function automatic logic rz();
        return 1'($urandom);
    endfunction

    // One cycle: drive inputs just after the edge, compare strobes at the falling edge.
    task automatic step(input logic rdy, input logic z, input logic [10:0] opc,
                        input logic [13:0] exp, input string tag);
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.opcode    = opc;
        if (exp[2]) exp_retire++;
        @(negedge clk);
        check(tag, {18'd0, obs()}, {18'd0, exp});
        @(posedge clk);
        #1;
    endtask

    // Memory wait: lat cycles without ready, then ready; longer than TIMEOUT aborts.
    task automatic mem_phase(input int lat, input logic [13:0] wait_v, input logic [13:0] done_v,
                             input string tag, output bit ok);
        for (int k = 0; k < lat && k < TIMEOUT; k++) step(1'b0, rz(), rop(), wait_v, {tag, "_wait"});
        if (lat <= TIMEOUT) begin
            step(1'b1, rz(), rop(), done_v, {tag, "_done"});
            ok = 1'b1;
        end else begin
            step(1'b0, rz(), rop(), BERR, {tag, "_timeout"});
            ok = 1'b0;
        end
    endtask

    task automatic run_instr(input logic [10:0] op, input int lf, input int lm, input logic zv);
        bit ok;
        int c;
        c = classify(op);
        mem_phase(lf, MRD, MRD | IRW | PCW, "fetch", ok);
        if (!ok) return;
        step(rz(), rz(), op, (c == C_ILL) ? ILL : 14'd0, "decode");
        case (c)
            C_R: begin
                step(rz(), rz(), rop(), A10, "exec_r");
                step(rz(), rz(), rop(), A10 | RW | DONE, "wb_alu_r");
            end
            C_I: begin
                step(rz(), rz(), rop(), A10 | SRC, "exec_i");
                step(rz(), rz(), rop(), A10 | SRC | RW | DONE, "wb_alu_i");
            end
            C_LD: begin
                step(rz(), rz(), rop(), SRC | R2L, "mem_addr_ld");
                mem_phase(lm, SRC | MRD, SRC | MRD, "mem_rd", ok);
                if (ok) step(rz(), rz(), rop(), M2R | RW | DONE, "wb_mem");
            end
            C_ST: begin
                step(rz(), rz(), rop(), SRC | R2L, "mem_addr_st");
                mem_phase(lm, SRC | R2L | MWR, SRC | R2L | MWR | DONE, "mem_wr", ok);
            end
            C_CBZ: step(rz(), zv, rop(), A01 | R2L | (zv ? PCW : 14'd0) | DONE, "branch_cbz");
            C_B:   step(rz(), rz(), rop(), UNC | PCW | DONE, "branch_b");
            default: ;
        endcase
    endtask

    function automatic int rlat();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3));
        return int'($urandom_range(0, 3));
    endfunction

    function automatic logic [10:0] pick_op();
        logic [10:0] r_ops [4];
        r_ops[0] = 11'b10001011000;
        r_ops[1] = 11'b11001011000;
        r_ops[2] = 11'b10001010000;
        r_ops[3] = 11'b10101010000;
        case ($urandom_range(0, 7))
            0: return r_ops[$urandom_range(0, 3)];
            1: return {10'b1001000100, 1'($urandom)};
            2: return 11'b11111000010;
            3: return 11'b11111000000;
            4: return {8'b10110100, 3'($urandom)};
            5: return {6'b000101, 5'($urandom)};
            6: return rop();
            default: return 11'h7ff;
        endcase
    endfunction

    initial begin
        bit ok;
        bus.opcode    = '0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        #3;
        check("reset_outputs", {18'd0, obs()}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", {18'd0, obs()}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Async reset while LDUR is waiting in MEM_RD.
        mem_phase(0, MRD, MRD | IRW | PCW, "fetch", ok);
        step(1'b0, 1'b0, 11'b11111000010, 14'd0, "decode");
        step(1'b0, 1'b0, rop(), SRC | R2L, "mem_addr_ld");
        step(1'b0, 1'b0, rop(), SRC | MRD, "mem_rd_wait");
        step(1'b0, 1'b0, rop(), SRC | MRD, "mem_rd_wait");
        bus.mem_ready = 1'b0;
        #2;
        check("pre_reset_mem_rd", {18'd0, obs()}, {18'd0, SRC | MRD});
        reset_n = 1'b0;
        #1;
        check("reset_async", {18'd0, obs()}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_instr(11'b10001011000, 0, 0, 1'b0);   // ADD
        run_instr(11'b11111000010, 0, 3, 1'b0);   // LDUR, ready after 3
        run_instr(11'b10110100101, 1, 0, 1'b1);   // CBZ taken
        run_instr(11'b10110100000, 0, 0, 1'b0);   // CBZ not taken
        run_instr(11'b11111000000, 0, 20, 1'b0);  // STUR timeout
        run_instr(11'b11111111111, 2, 0, 1'b0);   // illegal
        run_instr(11'b10010001001, 0, 0, 1'b0);   // ADDI
        run_instr(11'b00010110011, 0, 0, 1'b0);   // B
        run_instr(11'b10001011000, 16, 0, 1'b0);  // ready exactly at limit
        run_instr(11'b10001011000, 17, 0, 1'b0);  // fetch timeout
        run_instr(11'b11111000000, 0, 16, 1'b0);  // STUR ready at limit

        for (int i = 0; i < 200; i++) run_instr(pick_op(), rlat(), rlat(), rz());

        check("retire_count", 32'(seen_retire), 32'(exp_retire));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
